// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcode constants, ALU op/control codes, decoded entry struct.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package decode_stage_pkg;

    // Storage width of pc/imm in the decoded entry; the stage slices down to XLEN.
    localparam int XLEN_MAX = 64;
    localparam int REG_W    = 5;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_LOAD      = 7'b0000011;
    localparam opcode_t OPC_OP_IMM    = 7'b0010011;
    localparam opcode_t OPC_AUIPC     = 7'b0010111;
    localparam opcode_t OPC_OP_IMM_32 = 7'b0011011;
    localparam opcode_t OPC_STORE     = 7'b0100011;
    localparam opcode_t OPC_OP        = 7'b0110011;
    localparam opcode_t OPC_LUI       = 7'b0110111;
    localparam opcode_t OPC_OP_32     = 7'b0111011;
    localparam opcode_t OPC_BRANCH    = 7'b1100011;
    localparam opcode_t OPC_JALR      = 7'b1100111;
    localparam opcode_t OPC_JAL       = 7'b1101111;

    // Coarse ALU class chosen from the opcode; refined by funct3/funct7.
    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'd0,
        ALU_OP_BRANCH = 2'd1,
        ALU_OP_REG    = 2'd2,
        ALU_OP_IMM    = 2'd3
    } alu_op_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef logic [XLEN_MAX-1:0] imm_t;

    typedef struct packed {
        imm_t             pc;
        opcode_t          opcode;
        logic [2:0]       funct3;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        imm_t             imm;
        logic [3:0]       alu_ctrl;
        logic             illegal;
    } decoded_instr_t;

    // Sign-extend a 32-bit value to the full storage width.
    function automatic imm_t sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ALUdecoder.sv
// ALU control decoder: coarse ALU op plus funct3/funct7 -> 4-bit ALU control code.
// Latency: combinational.
// Backpressure: none.
module ALUdecoder
    import decode_stage_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl
);

    // Only funct7[5] selects between add/sub and srl/sra.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Map ALU class and function fields to a control code.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl = ALU_SLTU;
                    default:        alu_ctrl = ALU_ADD;
                endcase
            end
            ALU_OP_REG, ALU_OP_IMM: begin
                case (funct3)
                    // addi never subtracts: its funct7 slot is immediate bits
                    3'b000:  alu_ctrl = (alu_op == ALU_OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/decode_comb.sv
// Pure instruction decoder: raw word + pc -> decoded entry and source-usage flags.
// Latency: combinational.
// Backpressure: none.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic [31:0]    instr,
    input  imm_t           pc,
    output decoded_instr_t dec,
    output logic           rs1_used,
    output logic           rs2_used
);

    logic       is_r, is_i, is_s, is_b, is_u, is_j, legal;
    alu_op_t    alu_op;
    logic [6:0] funct7;
    logic [3:0] alu_raw;
    imm_t       imm;

    // Classify the opcode into an encoding format and ALU class.
    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_s   = 1'b0;
        is_b   = 1'b0;
        is_u   = 1'b0;
        is_j   = 1'b0;
        alu_op = ALU_OP_ADD;
        case (instr[6:0])
            OPC_OP:        begin is_r = 1'b1; alu_op = ALU_OP_REG; end
            OPC_OP_IMM:    begin is_i = 1'b1; alu_op = ALU_OP_IMM; end
            // word ops exist only on RV64; on RV32 they fall through as illegal
            OPC_OP_32:     if (XLEN == 64) begin is_r = 1'b1; alu_op = ALU_OP_REG; end
            OPC_OP_IMM_32: if (XLEN == 64) begin is_i = 1'b1; alu_op = ALU_OP_IMM; end
            OPC_LOAD,
            OPC_JALR:      is_i = 1'b1;
            OPC_STORE:     is_s = 1'b1;
            OPC_BRANCH:    begin is_b = 1'b1; alu_op = ALU_OP_BRANCH; end
            OPC_LUI,
            OPC_AUIPC:     is_u = 1'b1;
            OPC_JAL:       is_j = 1'b1;
            default:       ;
        endcase
    end

    assign legal    = is_r | is_i | is_s | is_b | is_u | is_j;
    assign rs1_used = is_r | is_i | is_s | is_b;
    assign rs2_used = is_r | is_s | is_b;
    // funct7 only carries meaning for register ops and immediate logic/shift ops
    assign funct7   = (is_r || (is_i && alu_op == ALU_OP_IMM)) ? instr[31:25] : 7'd0;

    ALUdecoder u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (instr[14:12]),
        .funct7   (funct7),
        .alu_ctrl (alu_raw)
    );

    // Assemble the sign-extended immediate for the detected format.
    always_comb begin
        imm = '0;
        if (is_i)      imm = sext32({{20{instr[31]}}, instr[31:20]});
        else if (is_s) imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        else if (is_b) imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        else if (is_j) imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
        else if (is_u) imm = sext32({instr[31:12], 12'd0});
    end

    // Build the decoded entry; unused fields and illegal words read as zero.
    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.opcode  = instr[6:0];
        dec.illegal = !legal;
        if (legal) begin
            dec.funct3   = (is_u || is_j) ? 3'd0 : instr[14:12];
            dec.rd       = (is_s || is_b) ? 5'd0 : instr[11:7];
            dec.rs1      = (is_u || is_j) ? 5'd0 : instr[19:15];
            dec.rs2      = rs2_used ? instr[24:20] : 5'd0;
            dec.imm      = imm;
            dec.alu_ctrl = alu_raw;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: fetch valid/ready in, decoded entry valid/ready out.
// Latency: 1 cycle from accept to out_valid; sustains 1 instr/cycle.
// Backpressure: 2-entry (main + skid) buffer; in_ready drops when skid full, on load-use hazard or flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int HAZARD_EN  = 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  ld_pending,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [XLEN-1:0]       out_imm,
    output logic [3:0]            out_alu_ctrl,
    output logic                  out_illegal
);

    localparam logic HAZ_ON = (HAZARD_EN != 0);

    decoded_instr_t dec_in, main_q, skid_q;
    logic           main_vld, skid_vld;
    logic           rs1_used, rs2_used, rs1_hit, rs2_hit;
    logic           hazard, accept, consume;
    logic           unused_hi;

    decode_comb #(.XLEN(XLEN)) u_decode (
        .instr    (in_instr),
        .pc       (imm_t'(in_pc)),
        .dec      (dec_in),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    // Load-use: hold the instruction while a pending load targets a source it reads.
    assign rs1_hit  = rs1_used && (REG_ADDR_W'(dec_in.rs1) == ld_rd);
    assign rs2_hit  = rs2_used && (REG_ADDR_W'(dec_in.rs2) == ld_rd);
    assign hazard   = HAZ_ON && in_valid && ld_pending && (ld_rd != '0) && (rs1_hit || rs2_hit);

    assign in_ready = !reset && !skid_vld && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign consume  = main_vld && out_ready;

    // Main/skid buffer: main feeds the outputs, skid catches one entry under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (consume) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= dec_in;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                main_q   <= dec_in;
                main_vld <= 1'b1;
            end else begin
                skid_q   <= dec_in;
                skid_vld <= 1'b1;
            end
        end
    end

    assign out_valid    = main_vld;
    assign out_pc       = main_q.pc[XLEN-1:0];
    assign out_opcode   = main_q.opcode;
    assign out_funct3   = main_q.funct3;
    assign out_rd       = REG_ADDR_W'(main_q.rd);
    assign out_rs1      = REG_ADDR_W'(main_q.rs1);
    assign out_rs2      = REG_ADDR_W'(main_q.rs2);
    assign out_imm      = main_q.imm[XLEN-1:0];
    assign out_alu_ctrl = main_q.alu_ctrl;
    assign out_illegal  = main_q.illegal;

    // Bits above XLEN are stored but never presented on RV32 builds.
    assign unused_hi = ^{main_q.pc, main_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven decode vectors plus handshake corner sequences.
// Latency: n/a.
// Backpressure: exercised via out_ready, hazard and flush sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, ld_pending;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;
    logic [4:0]  ld_rd;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_alu_ctrl;

    logic        in_ready_64, out_valid_64, out_illegal_64;
    logic [63:0] out_pc_64, out_imm_64;
    logic [6:0]  out_opcode_64;
    logic [2:0]  out_funct3_64;
    logic [4:0]  out_rd_64, out_rs1_64, out_rs2_64;
    logic [3:0]  out_alu_ctrl_64;

    int checks   = 0;
    int failures = 0;

    assign in_pc64 = {32'h0, in_pc};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .REG_ADDR_W(5), .HAZARD_EN(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ld_pending(ld_pending), .ld_rd(ld_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_alu_ctrl(out_alu_ctrl), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64), .REG_ADDR_W(5), .HAZARD_EN(1)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_pc(in_pc64),
        .ld_pending(ld_pending), .ld_rd(ld_rd),
        .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(out_pc_64),
        .out_opcode(out_opcode_64), .out_funct3(out_funct3_64), .out_rd(out_rd_64),
        .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_imm(out_imm_64),
        .out_alu_ctrl(out_alu_ctrl_64), .out_illegal(out_illegal_64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        ill;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        //            instr         opc    f3    rd     rs1    rs2    imm            alu    ill
        vecs[0]  = '{32'hFFF10093, 7'h13, 3'd0, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 4'd0, 1'b0}; // addi x1,x2,-1
        vecs[1]  = '{32'h004101B3, 7'h33, 3'd0, 5'd3,  5'd2,  5'd4,  32'h00000000, 4'd0, 1'b0}; // add x3,x2,x4
        vecs[2]  = '{32'h404101B3, 7'h33, 3'd0, 5'd3,  5'd2,  5'd4,  32'h00000000, 4'd1, 1'b0}; // sub x3,x2,x4
        vecs[3]  = '{32'h00512423, 7'h23, 3'd2, 5'd0,  5'd2,  5'd5,  32'h00000008, 4'd0, 1'b0}; // sw x5,8(x2)
        vecs[4]  = '{32'hFE208EE3, 7'h63, 3'd0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 4'd1, 1'b0}; // beq x1,x2,-4
        vecs[5]  = '{32'h001000EF, 7'h6F, 3'd0, 5'd1,  5'd0,  5'd0,  32'h00000800, 4'd0, 1'b0}; // jal x1,2048
        vecs[6]  = '{32'hFF83A303, 7'h03, 3'd2, 5'd6,  5'd7,  5'd0,  32'hFFFFFFF8, 4'd0, 1'b0}; // lw x6,-8(x7)
        vecs[7]  = '{32'h40315093, 7'h13, 3'd5, 5'd1,  5'd2,  5'd0,  32'h00000403, 4'd7, 1'b0}; // srai x1,x2,3
        vecs[8]  = '{32'hFFFFF517, 7'h17, 3'd0, 5'd10, 5'd0,  5'd0,  32'hFFFFF000, 4'd0, 1'b0}; // auipc x10,0xFFFFF
        vecs[9]  = '{32'hFFFFFFFF, 7'h7F, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 4'd0, 1'b1}; // illegal
        vecs[10] = '{32'h0041E863, 7'h63, 3'd6, 5'd0,  5'd3,  5'd4,  32'h00000010, 4'd4, 1'b0}; // bltu x3,x4,16
        vecs[11] = '{32'h003140B3, 7'h33, 3'd4, 5'd1,  5'd2,  5'd3,  32'h00000000, 4'd5, 1'b0}; // xor x1,x2,x3
        vecs[12] = '{32'h00008067, 7'h67, 3'd0, 5'd0,  5'd1,  5'd0,  32'h00000000, 4'd0, 1'b0}; // jalr x0,0(x1)
        vecs[13] = '{32'h003100BB, 7'h3B, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 4'd0, 1'b1}; // addw: RV64 only

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; ld_pending = 1'b0; ld_rd = 5'd0;
        drive(1'b1, 32'hFFF10093, 32'h0000_0040);
        step();
        step();
        // ---- reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_illegal", out_illegal, 0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // ---- table-driven decode, streamed one per cycle with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4);
            step();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d_opcode", i), out_opcode, vecs[i].opc);
            chk($sformatf("v%0d_funct3", i), out_funct3, vecs[i].f3);
            chk($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d_rs1", i), out_rs1, vecs[i].rs1);
            chk($sformatf("v%0d_rs2", i), out_rs2, vecs[i].rs2);
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d_alu", i), out_alu_ctrl, vecs[i].alu);
            chk($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
        end
        // addw was the last vector: legal on the RV64 build
        chk("rv64_addw_illegal", out_illegal_64, 0);
        chk("rv64_addw_rd", out_rd_64, 1);
        chk("rv64_addw_rs2", out_rs2_64, 3);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("drain_out_valid", out_valid, 0);

        // ---- lui on XLEN=64 and XLEN=32
        drive(1'b1, 32'h123452B7, 32'h2000);
        step();
        chk("lui64_imm", out_imm_64, 64'h0000_0000_1234_5000);
        chk("lui64_rd", out_rd_64, 5);
        chk("lui64_rs1", out_rs1_64, 0);
        drive(1'b1, 32'h800002B7, 32'h2004);
        step();
        chk("lui64_neg_imm", out_imm_64, 64'hFFFF_FFFF_8000_0000);
        chk("lui32_neg_imm", out_imm, 32'h8000_0000);
        chk("lui64_pc", out_pc_64, 64'h2004);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // ---- backpressure: two accepted, third held, then drained in order
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h3000);
        #1;
        chk("bp_ready_a", in_ready, 1);
        step();
        chk("bp_valid_a", out_valid, 1);
        chk("bp_pc_a", out_pc, 32'h3000);
        drive(1'b1, 32'h00200113, 32'h3004);
        #1;
        chk("bp_ready_b", in_ready, 1);
        step();
        drive(1'b1, 32'h00300193, 32'h3008);
        #1;
        chk("bp_ready_c_blocked", in_ready, 0);
        step();
        chk("bp_hold_pc", out_pc, 32'h3000);
        chk("bp_hold_rd", out_rd, 1);
        chk("bp_still_blocked", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_drain_b_valid", out_valid, 1);
        chk("bp_drain_b_pc", out_pc, 32'h3004);
        chk("bp_ready_c", in_ready, 1);
        step();
        chk("bp_drain_c_valid", out_valid, 1);
        chk("bp_drain_c_pc", out_pc, 32'h3008);
        chk("bp_drain_c_rd", out_rd, 3);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("bp_empty", out_valid, 0);

        // ---- load-use hazard
        ld_pending = 1'b1;
        ld_rd      = 5'd2;
        drive(1'b1, 32'h004101B3, 32'h4000);
        #1;
        chk("hz_rs1_stall", in_ready, 0);
        step();
        step();
        chk("hz_no_out", out_valid, 0);
        ld_pending = 1'b0;
        #1;
        chk("hz_release", in_ready, 1);
        step();
        chk("hz_out_valid", out_valid, 1);
        chk("hz_out_rd", out_rd, 3);
        ld_pending = 1'b1;
        ld_rd      = 5'd4;
        #1;
        chk("hz_rs2_stall", in_ready, 0);
        ld_rd = 5'd0;
        #1;
        chk("hz_ldrd0_nostall", in_ready, 1);
        ld_rd = 5'd5;
        drive(1'b1, 32'h123452B7, 32'h4004);
        #1;
        chk("hz_lui_nostall", in_ready, 1);
        drive(1'b1, 32'h00512423, 32'h4008);
        #1;
        chk("hz_store_rs2_stall", in_ready, 0);
        drive(1'b0, 32'h0, 32'h0);
        ld_pending = 1'b0;
        step();
        step();

        // ---- flush with both entries full
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h5000);
        step();
        drive(1'b1, 32'h00200113, 32'h5004);
        step();
        drive(1'b1, 32'h00300193, 32'h5008);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_skid_cleared", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", out_valid, 0);
        // flush on an empty stage still refuses the input
        drive(1'b1, 32'h00100093, 32'h5100);
        flush = 1'b1;
        #1;
        chk("fl_empty_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("fl_empty_not_accepted", out_valid, 0);

        // ---- all-zero word is illegal but flows with its pc
        drive(1'b1, 32'h0000_0000, 32'hDEAD_0000);
        step();
        chk("z_valid", out_valid, 1);
        chk("z_illegal", out_illegal, 1);
        chk("z_pc", out_pc, 32'hDEAD_0000);
        chk("z_imm", out_imm, 0);

        // ---- asynchronous reset mid-stream with both entries held
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h6000);
        step();
        drive(1'b1, 32'h00200113, 32'h6004);
        step();
        reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_out_pc", out_pc, 0);
        #2;
        reset = 1'b0;
        drive(1'b1, 32'h00700393, 32'h6100);
        #1;
        chk("ar_ready_back", in_ready, 1);
        step();
        chk("ar_new_valid", out_valid, 1);
        chk("ar_new_pc", out_pc, 32'h6100);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        chk("ar_no_leftover", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
